pwm_out: RTL and testbench



---
 rtl/sass_pkg.sv | 13 +
 rtl/pwm_prescaler.sv | 38 +++
 rtl/pwm_out.sv | 125 ++++++++++++
 tb/tb_pwm_out.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sass_pkg.sv
// Shared definitions for the sample path and the PWM output stage.
package sass_pkg;

    localparam int unsigned SAMPLE_W = 8;

    localparam logic [SAMPLE_W-1:0] PWM_CNT_MAX = 8'd255;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } pwm_state_t;

endpackage

// File: rtl/pwm_prescaler.sv
// Divides clk into PWM counter ticks; one tick every PRESCALE cycles while not cleared.
module pwm_prescaler #(
    parameter int unsigned PRESCALE = 1
) (
    input  logic clk,
    input  logic n_rst,
    input  logic clear,
    output logic tick
);

    localparam int unsigned PS_W = 8;

    logic [PS_W-1:0] ps_q;
    logic [PS_W-1:0] ps_d;

    // Tick on the last count of each prescale window; suppressed while cleared.
    assign tick = !clear && (ps_q == PS_W'(PRESCALE - 1));

    // Next prescale count: restart on clear or at the end of a window.
    always_comb begin
        ps_d = ps_q;
        if (clear || tick) begin
            ps_d = '0;
        end else begin
            ps_d = ps_q + PS_W'(1);
        end
    end

    // Prescale count register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            ps_q <= '0;
        end else begin
            ps_q <= ps_d;
        end
    end

endmodule

// File: rtl/pwm_out.sv
// PWM output stage: 8-bit duty captured once per period, glitch-free 1-bit output.
// Define PWM_CENTER_ALIGNED_EN for an up/down (centre-aligned, 512-tick) period.
module pwm_out
    import sass_pkg::*;
#(
    parameter int unsigned PRESCALE = 1
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                en,
    input  logic [SAMPLE_W-1:0] sample,
    output logic                pwm_o,
    output logic                period_start,
    output logic [SAMPLE_W-1:0] duty_q
);

    pwm_state_t          state_q, state_d;
    logic [SAMPLE_W-1:0] cnt_q, cnt_d;
    logic [SAMPLE_W-1:0] duty_d;
    logic                period_start_q, period_start_d;
    logic                tick;
    logic                ps_clear;
`ifdef PWM_CENTER_ALIGNED_EN
    logic                up_q, up_d;
`endif

    // Prescaler idles at zero outside RUN and restarts on the disabling edge.
    assign ps_clear = (state_q == IDLE) || !en;

    pwm_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk   (clk),
        .n_rst (n_rst),
        .clear (ps_clear),
        .tick  (tick)
    );

    // Next-state logic: enable handling, period counter and duty capture.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        duty_d         = duty_q;
        period_start_d = 1'b0;
`ifdef PWM_CENTER_ALIGNED_EN
        up_d           = up_q;
`endif
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (en) begin
                    state_d        = RUN;
                    duty_d         = sample;
                    period_start_d = 1'b1;
`ifdef PWM_CENTER_ALIGNED_EN
                    up_d           = 1'b1;
`endif
                end
            end
            RUN: begin
                if (!en) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (tick) begin
`ifdef PWM_CENTER_ALIGNED_EN
                    // Endpoints are held for one extra tick while turning round.
                    if (up_q) begin
                        if (cnt_q == PWM_CNT_MAX) begin
                            up_d = 1'b0;
                        end else begin
                            cnt_d = cnt_q + SAMPLE_W'(1);
                        end
                    end else begin
                        if (cnt_q == '0) begin
                            up_d           = 1'b1;
                            duty_d         = sample;
                            period_start_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q - SAMPLE_W'(1);
                        end
                    end
`else
                    if (cnt_q == PWM_CNT_MAX) begin
                        cnt_d          = '0;
                        duty_d         = sample;
                        period_start_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + SAMPLE_W'(1);
                    end
`endif
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State, counter and captured-duty registers.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            duty_q         <= '0;
            period_start_q <= 1'b0;
`ifdef PWM_CENTER_ALIGNED_EN
            up_q           <= 1'b1;
`endif
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            duty_q         <= duty_d;
            period_start_q <= period_start_d;
`ifdef PWM_CENTER_ALIGNED_EN
            up_q           <= up_d;
`endif
        end
    end

    // Output decoded from registers only, so live sample changes never reach the pin.
    assign pwm_o        = (state_q == RUN) && (cnt_q < duty_q);
    assign period_start = period_start_q;

endmodule

// File: tb/tb_pwm_out.sv
// Bench for pwm_out: PRESCALE=1 and PRESCALE=4 instances driven in parallel.
module tb_pwm_out;

`ifdef PWM_CENTER_ALIGNED_EN
    localparam int PER_TICKS = 512;
    localparam int MULT      = 2;
    localparam int PS1_N     = 2;
`else
    localparam int PER_TICKS = 256;
    localparam int MULT      = 1;
    localparam int PS1_N     = 4;
`endif

    logic       clk;
    logic       n_rst;
    logic       en;
    logic [7:0] sample;
    logic       pwm1, ps1, pwm4, ps4;
    logic [7:0] duty1, duty4;

    int checks;
    int fails;

    pwm_out #(.PRESCALE(1)) dut1 (
        .clk(clk), .n_rst(n_rst), .en(en), .sample(sample),
        .pwm_o(pwm1), .period_start(ps1), .duty_q(duty1)
    );

    pwm_out #(.PRESCALE(4)) dut4 (
        .clk(clk), .n_rst(n_rst), .en(en), .sample(sample),
        .pwm_o(pwm4), .period_start(ps4), .duty_q(duty4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: running flag, clocks elapsed in the current period, captured duty.
    logic m_run  [2];
    int   m_t    [2];
    int   m_duty [2];

    function automatic int pre_of(input int i);
        return (i == 0) ? 1 : 4;
    endfunction

    function automatic int plen_of(input int i);
        return PER_TICKS * pre_of(i);
    endfunction

    always @(posedge clk or negedge n_rst) begin
        for (int i = 0; i < 2; i++) begin
            if (!n_rst) begin
                m_run[i]  <= 1'b0;
                m_t[i]    <= 0;
                m_duty[i] <= 0;
            end else if (!en) begin
                m_run[i] <= 1'b0;
                m_t[i]   <= 0;
            end else if (!m_run[i]) begin
                m_run[i]  <= 1'b1;
                m_t[i]    <= 0;
                m_duty[i] <= int'(sample);
            end else if (m_t[i] == plen_of(i) - 1) begin
                m_t[i]    <= 0;
                m_duty[i] <= int'(sample);
            end else begin
                m_t[i] <= m_t[i] + 1;
            end
        end
    end

    // Counter position implied by elapsed time within the period.
    function automatic int exp_cnt(input int i);
        int j;
        j = m_t[i] / pre_of(i);
`ifdef PWM_CENTER_ALIGNED_EN
        return (j < 256) ? j : 511 - j;
`else
        return j;
`endif
    endfunction

    function automatic int exp_pwm(input int i);
        return (m_run[i] && (exp_cnt(i) < m_duty[i])) ? 1 : 0;
    endfunction

    function automatic int exp_ps(input int i);
        return (m_run[i] && (m_t[i] == 0)) ? 1 : 0;
    endfunction

    task automatic cmp(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s got=%0d want=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all();
        cmp("dut1.pwm_o",        int'(pwm1),  exp_pwm(0));
        cmp("dut1.period_start", int'(ps1),   exp_ps(0));
        cmp("dut1.duty_q",       int'(duty1), m_duty[0]);
        cmp("dut4.pwm_o",        int'(pwm4),  exp_pwm(1));
        cmp("dut4.period_start", int'(ps4),   exp_ps(1));
        cmp("dut4.duty_q",       int'(duty4), m_duty[1]);
    endtask

    // Advance one clock and compare every output against the model.
    task automatic step();
        @(negedge clk);
        check_all();
    endtask

    typedef struct {
        logic [7:0] smp;
        int         exp_high;
        int         exp_ps1;
        int         exp_ps4;
    } vec_t;

    initial begin
        vec_t vecs [7];
        int   h1, h4, p1, p4, any_hi;

        checks = 0;
        fails  = 0;

        // Over 1024 clk from a fresh enable both instances are high for 4*sample clk.
        vecs[0] = '{smp: 8'd0,   exp_high: 0,    exp_ps1: PS1_N, exp_ps4: 1};
        vecs[1] = '{smp: 8'd1,   exp_high: 4,    exp_ps1: PS1_N, exp_ps4: 1};
        vecs[2] = '{smp: 8'd10,  exp_high: 40,   exp_ps1: PS1_N, exp_ps4: 1};
        vecs[3] = '{smp: 8'd64,  exp_high: 256,  exp_ps1: PS1_N, exp_ps4: 1};
        vecs[4] = '{smp: 8'd128, exp_high: 512,  exp_ps1: PS1_N, exp_ps4: 1};
        vecs[5] = '{smp: 8'd254, exp_high: 1016, exp_ps1: PS1_N, exp_ps4: 1};
        vecs[6] = '{smp: 8'd255, exp_high: 1020, exp_ps1: PS1_N, exp_ps4: 1};

        // Reset and idle with a nonzero sample present.
        n_rst  = 1'b0;
        en     = 1'b0;
        sample = 8'h80;
        step();
        cmp("reset.pwm_o",        int'(pwm1 | pwm4), 0);
        cmp("reset.period_start", int'(ps1 | ps4),   0);
        cmp("reset.duty_q",       int'(duty1 | duty4), 0);
        step();
        n_rst  = 1'b1;
        any_hi = 0;
        for (int c = 0; c < 600; c++) begin
            step();
            any_hi += int'(pwm1 | pwm4 | ps1 | ps4) + int'(duty1 | duty4);
        end
        cmp("idle.any_activity", any_hi, 0);

        // Table of duties: high time and period_start count over 1024 clk.
        foreach (vecs[v]) begin
            en = 1'b0;
            step();
            step();
            sample = vecs[v].smp;
            en     = 1'b1;
            h1 = 0; h4 = 0; p1 = 0; p4 = 0;
            for (int c = 0; c < 1024; c++) begin
                step();
                h1 += int'(pwm1);
                h4 += int'(pwm4);
                p1 += int'(ps1);
                p4 += int'(ps4);
            end
            cmp($sformatf("vec%0d.dut1_high", v), h1, vecs[v].exp_high);
            cmp($sformatf("vec%0d.dut4_high", v), h4, vecs[v].exp_high);
            cmp($sformatf("vec%0d.dut1_starts", v), p1, vecs[v].exp_ps1);
            cmp($sformatf("vec%0d.dut4_starts", v), p4, vecs[v].exp_ps4);
        end

        // Sample change mid-period only takes effect at the next boundary.
        en = 1'b0;
        step();
        step();
        sample = 8'd200;
        en     = 1'b1;
        h1 = 0;
        for (int c = 0; c < PER_TICKS; c++) begin
            step();
            if (c == 100) sample = 8'd20;
            h1 += int'(pwm1);
            if (c == PER_TICKS - 1) cmp("midchg.duty_before", int'(duty1), 200);
        end
        cmp("midchg.high_first", h1, 200 * MULT);
        h1 = 0;
        for (int c = 0; c < PER_TICKS; c++) begin
            step();
            if (c == 0) begin
                cmp("midchg.start", int'(ps1), 1);
                cmp("midchg.duty_after", int'(duty1), 20);
            end
            h1 += int'(pwm1);
        end
        cmp("midchg.high_second", h1, 20 * MULT);

        // Enable drop at cnt=50, then re-enable with a new duty.
        en = 1'b0;
        step();
        step();
        sample = 8'd100;
        en     = 1'b1;
        repeat (51) step();
        en = 1'b0;
        step();
        cmp("endrop.pwm_o", int'(pwm1), 0);
        cmp("endrop.duty_held", int'(duty1), 100);
        cmp("endrop.period_start", int'(ps1), 0);
        sample = 8'd30;
        en     = 1'b1;
        step();
        cmp("reen.start", int'(ps1), 1);
        cmp("reen.duty", int'(duty1), 30);
        h1 = int'(pwm1);
        for (int c = 1; c < PER_TICKS; c++) begin
            step();
            h1 += int'(pwm1);
        end
        cmp("reen.high", h1, 30 * MULT);

        // Asynchronous reset in the middle of a high pulse.
        en = 1'b0;
        step();
        sample = 8'd128;
        en     = 1'b1;
        repeat (10) step();
        cmp("arst.pre_high", int'(pwm1 & pwm4), 1);
        #2;
        n_rst = 1'b0;
        #1;
        cmp("arst.pwm_o", int'(pwm1 | pwm4), 0);
        cmp("arst.duty_q", int'(duty1 | duty4), 0);
        cmp("arst.period_start", int'(ps1 | ps4), 0);
        step();
        step();
        n_rst = 1'b1;

        // Randomized enable, sample and reset activity against the model.
        for (int c = 0; c < 3000; c++) begin
            step();
            if ($urandom_range(39, 0) == 0) en = ~en;
            if ($urandom_range(7, 0) == 0) sample = 8'($urandom);
            if (n_rst == 1'b0) n_rst = 1'b1;
            else if ($urandom_range(699, 0) == 0) n_rst = 1'b0;
        end
        n_rst = 1'b1;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
